huc_rom_port: RTL and testbench
===============================

# huc_rom_port

Downstream memory port for the HuCard mapper stage. It consumes the flattened ROM/RAM request that a mapper drives (ce, oe, we, addr, dati) and runs timed read and write cycles on the 16-bit asynchronous PSRAM that holds the cartridge image. It returns the selected byte on `dato`, which the mapper forwards as its ROM or RAM read data. A one-word read cache and a one-deep pending slot absorb back-to-back CPU accesses.

## Interface
Parameters:
- `WAIT_RD`, default 4: read strobe length in clk cycles (≥1).
- `WAIT_WR`, default 4: write strobe length in clk cycles (≥1).
- `REC`, default 1: recovery cycles with all strobes high after each memory cycle (≥0).

Ports:
- `clk` in 1: the single clock; all logic runs on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ce` in 1: request select from the mapper.
- `oe` in 1: read strobe from the mapper.
- `we` in 1: write strobe from the mapper.
- `addr` in 20: byte address from the mapper.
- `dati` in 8: write data from the mapper.
- `dato` out 8: read data byte.
- `busy` out 1: high while a memory cycle or recovery is in progress.
- `ovf` out 1: sticky flag; a request was dropped.
- `mem_addr` out 19: PSRAM word address.
- `mem_dq_i` in 16: PSRAM read data.
- `mem_dq_o` out 16: PSRAM write data.
- `mem_dq_oe` out 1: PSRAM data output enable.
- `mem_ce_n`, `mem_oe_n`, `mem_we_n`, `mem_ub_n`, `mem_lb_n` out 1 each: PSRAM strobes, active low.

Inputs are already synchronous to `clk`. All outputs are registered.

## Operation
Request detection:
- `rd_req` is the rising edge of `ce & oe`, detected against the previous-cycle registered value.
- `wr_req` is the rising edge of `ce & we`.
- If both fire on the same edge, the access is treated as a write only.

FSM states: IDLE, RD, WR, REC.

IDLE + read hit (cache valid and `addr[19:1]` == tag):
- `dato` ← cached byte `addr[0]` (0 selects the low byte).
- No memory cycle; stay in IDLE.

IDLE + read miss → RD:
- `mem_addr` = `addr[19:1]`.
- `mem_ce_n` = 0, `mem_oe_n` = 0, `mem_ub_n` = 0, `mem_lb_n` = 0.
- The counter loads `WAIT_RD`.

RD:
- The counter decrements each cycle.
- On the terminal edge:
  - `mem_dq_i` → cache word.
  - tag ← word address; cache valid ← 1.
  - `dato` ← selected byte.
  - Strobes go high; state → REC (or IDLE if `REC` = 0).

IDLE + write → WR:
- `mem_dq_o` = {dati, dati}, `mem_dq_oe` = 1.
- `mem_ce_n` = 0, `mem_we_n` = 0.
- `mem_lb_n` = `addr[0]`, `mem_ub_n` = ~`addr[0]`.
- If the write hits the cached word, the matching cache byte is updated (write-through).

WR:
- Held for `WAIT_WR` cycles.
- Then strobes go high, `mem_dq_oe` = 0, state → REC or IDLE.

REC:
- Counts `REC` cycles with all strobes high, then → IDLE.

Pending slot (one deep):
- A request edge while the state is not IDLE stores {type, addr, dati} and sets the pending flag.
- On the first cycle in IDLE, a pending request is launched exactly as a new request, including the hit check.
- A request edge while the pending flag is already set is dropped and sets `ovf`.
- A new edge in the same cycle that the pending request launches goes into the now-free slot.

`busy` = (state ≠ IDLE) | pending.

Reset (async `rst` high, at any point, including mid-cycle):
- State IDLE, counter 0.
- All `mem_*_n` = 1, `mem_dq_oe` = 0, `mem_dq_o` = 0, `mem_addr` = 0.
- `dato` = 8'hFF, `busy` = 0, `ovf` = 0.
- Cache invalid, pending cleared, edge registers = 0.

## Timing
E0 is the first clk edge at which the strobe condition is sampled high.

- Read hit: `dato` updates at E0; latency 1 edge; `busy` stays 0.
- Read miss:
  - Strobes low from E0 to E0+`WAIT_RD`.
  - Data sampled and `dato` valid at E0+`WAIT_RD`.
  - Back in IDLE at E0+`WAIT_RD`+`REC`.
- Write:
  - `mem_we_n` low from E0 to E0+`WAIT_WR`.
  - IDLE at E0+`WAIT_WR`+`REC`.
- Pending request: launches on the edge after the state returns to IDLE.
- Address/data stability:
  - `mem_addr` and `mem_dq_o` change only when leaving IDLE.
  - `mem_dq_oe` never overlaps `mem_oe_n` = 0.
- `ovf` never clears except by `rst`.

## Test plan
- Reset check: assert `rst` mid-read, two cycles into RD → same cycle all `mem_*_n` = 1, `dato` = FF, `busy` = 0, `ovf` = 0. After release, a read of 0x00001 is a miss.
- Read miss then hit (`WAIT_RD` = 4, `REC` = 1, PSRAM word 0 = 0xBEEF):
  - Read 0x00000 → `dato` = EF at E0+4, `busy` low at E0+5.
  - Read 0x00001 → `dato` = BE at E0, no `mem_ce_n` pulse.
- Write: write 0x5A to 0x00003 → `mem_addr` = 1, `mem_ub_n` = 0, `mem_lb_n` = 1, `mem_dq_o` = 5A5A, `mem_we_n` low exactly 4 cycles.
- Write-through: with word 1 cached, write 0x77 to 0x00002, then read 0x00002 → `dato` = 77, no read cycle.
- Pending and overflow: during a miss on 0x10000, issue read 0x20000, then write 0x30000.
  - Second request (read 0x20000) runs after REC.
  - Third request (write 0x30000) is dropped; `ovf` = 1.
- Simultaneous strobes: `oe` and `we` rise together at 0x00004 with `dati` = 0x11 → only a WR cycle, no RD; `dato` unchanged.

Source files
------------

// File: rtl/huc_rom_port.sv
// huc_rom_port
// Downstream PSRAM port for the HuCard mapper stage. Turns the mapper's
// flattened ROM/RAM request into timed read/write cycles on a 16-bit
// asynchronous PSRAM and returns the selected byte on dato. A one-word read
// cache and a one-deep pending slot absorb back-to-back CPU accesses.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ce, oe, we          request select / read strobe / write strobe
//   addr[19:0]          byte address, dati[7:0] write data
//   dato[7:0]           read data byte
//   busy                memory cycle, recovery or pending request outstanding
//   ovf                 sticky: a request was dropped
//   mem_addr[18:0]      PSRAM word address
//   mem_dq_i/o[15:0]    PSRAM data in / out, mem_dq_oe output enable
//   mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n   active-low strobes
module huc_rom_port #(
    parameter int WAIT_RD = 4,
    parameter int WAIT_WR = 4,
    parameter int REC     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        oe,
    input  logic        we,
    input  logic [19:0] addr,
    input  logic [7:0]  dati,
    output logic [7:0]  dato,
    output logic        busy,
    output logic        ovf,
    output logic [18:0] mem_addr,
    input  logic [15:0] mem_dq_i,
    output logic [15:0] mem_dq_o,
    output logic        mem_dq_oe,
    output logic        mem_ce_n,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    output logic        mem_ub_n,
    output logic        mem_lb_n
);

    localparam int CW = 16;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_REC} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          rd_prev, wr_prev;
    logic [15:0]   cache_word, cache_word_nxt;
    logic [18:0]   cache_tag, cache_tag_nxt;
    logic          cache_valid, cache_valid_nxt;
    logic          byte_sel, byte_sel_nxt;
    logic          pend_valid, pend_valid_nxt;
    logic          pend_wr, pend_wr_nxt;
    logic [19:0]   pend_addr, pend_addr_nxt;
    logic [7:0]    pend_dati, pend_dati_nxt;
    logic [7:0]    dato_nxt;
    logic          busy_nxt, ovf_nxt;
    logic [18:0]   mem_addr_nxt;
    logic [15:0]   mem_dq_o_nxt;
    logic          mem_dq_oe_nxt;
    logic          mem_ce_n_nxt, mem_oe_n_nxt, mem_we_n_nxt, mem_ub_n_nxt, mem_lb_n_nxt;

    logic          rd_req, wr_req, new_req;
    logic          launch, l_wr;
    logic [19:0]   l_addr;
    logic [7:0]    l_dati;

    // A simultaneous read and write edge is treated as a write only.
    assign wr_req  = ce & we & ~wr_prev;
    assign rd_req  = ce & oe & ~rd_prev & ~wr_req;
    assign new_req = rd_req | wr_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            rd_prev     <= 1'b0;
            wr_prev     <= 1'b0;
            cache_word  <= '0;
            cache_tag   <= '0;
            cache_valid <= 1'b0;
            byte_sel    <= 1'b0;
            pend_valid  <= 1'b0;
            pend_wr     <= 1'b0;
            pend_addr   <= '0;
            pend_dati   <= '0;
            dato        <= 8'hFF;
            busy        <= 1'b0;
            ovf         <= 1'b0;
            mem_addr    <= '0;
            mem_dq_o    <= '0;
            mem_dq_oe   <= 1'b0;
            mem_ce_n    <= 1'b1;
            mem_oe_n    <= 1'b1;
            mem_we_n    <= 1'b1;
            mem_ub_n    <= 1'b1;
            mem_lb_n    <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rd_prev     <= ce & oe;
            wr_prev     <= ce & we;
            cache_word  <= cache_word_nxt;
            cache_tag   <= cache_tag_nxt;
            cache_valid <= cache_valid_nxt;
            byte_sel    <= byte_sel_nxt;
            pend_valid  <= pend_valid_nxt;
            pend_wr     <= pend_wr_nxt;
            pend_addr   <= pend_addr_nxt;
            pend_dati   <= pend_dati_nxt;
            dato        <= dato_nxt;
            busy        <= busy_nxt;
            ovf         <= ovf_nxt;
            mem_addr    <= mem_addr_nxt;
            mem_dq_o    <= mem_dq_o_nxt;
            mem_dq_oe   <= mem_dq_oe_nxt;
            mem_ce_n    <= mem_ce_n_nxt;
            mem_oe_n    <= mem_oe_n_nxt;
            mem_we_n    <= mem_we_n_nxt;
            mem_ub_n    <= mem_ub_n_nxt;
            mem_lb_n    <= mem_lb_n_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        cache_word_nxt  = cache_word;
        cache_tag_nxt   = cache_tag;
        cache_valid_nxt = cache_valid;
        byte_sel_nxt    = byte_sel;
        pend_valid_nxt  = pend_valid;
        pend_wr_nxt     = pend_wr;
        pend_addr_nxt   = pend_addr;
        pend_dati_nxt   = pend_dati;
        dato_nxt        = dato;
        ovf_nxt         = ovf;
        mem_addr_nxt    = mem_addr;
        mem_dq_o_nxt    = mem_dq_o;
        mem_dq_oe_nxt   = mem_dq_oe;
        mem_ce_n_nxt    = mem_ce_n;
        mem_oe_n_nxt    = mem_oe_n;
        mem_we_n_nxt    = mem_we_n;
        mem_ub_n_nxt    = mem_ub_n;
        mem_lb_n_nxt    = mem_lb_n;
        launch          = 1'b0;
        l_wr            = 1'b0;
        l_addr          = addr;
        l_dati          = dati;

        case (state)
            S_IDLE: begin
                // The pending request has priority over a fresh edge.
                if (pend_valid) begin
                    launch         = 1'b1;
                    l_wr           = pend_wr;
                    l_addr         = pend_addr;
                    l_dati         = pend_dati;
                    pend_valid_nxt = 1'b0;
                end else if (new_req) begin
                    launch = 1'b1;
                    l_wr   = wr_req;
                end
            end
            S_RD: begin
                if (cnt == CW'(1)) begin
                    cache_word_nxt  = mem_dq_i;
                    cache_tag_nxt   = mem_addr;
                    cache_valid_nxt = 1'b1;
                    dato_nxt        = byte_sel ? mem_dq_i[15:8] : mem_dq_i[7:0];
                    mem_ce_n_nxt    = 1'b1;
                    mem_oe_n_nxt    = 1'b1;
                    mem_ub_n_nxt    = 1'b1;
                    mem_lb_n_nxt    = 1'b1;
                    state_nxt       = (REC == 0) ? S_IDLE : S_REC;
                    cnt_nxt         = CW'(REC);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_WR: begin
                if (cnt == CW'(1)) begin
                    mem_ce_n_nxt  = 1'b1;
                    mem_we_n_nxt  = 1'b1;
                    mem_ub_n_nxt  = 1'b1;
                    mem_lb_n_nxt  = 1'b1;
                    mem_dq_oe_nxt = 1'b0;
                    state_nxt     = (REC == 0) ? S_IDLE : S_REC;
                    cnt_nxt       = CW'(REC);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_REC: begin
                if (cnt <= CW'(1)) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Slot capture: the slot is free either because it is empty or
        // because its occupant launches this very cycle.
        if (new_req && (state != S_IDLE || pend_valid)) begin
            if (state != S_IDLE && pend_valid) begin
                ovf_nxt = 1'b1;
            end else begin
                pend_valid_nxt = 1'b1;
                pend_wr_nxt    = wr_req;
                pend_addr_nxt  = addr;
                pend_dati_nxt  = dati;
            end
        end

        if (launch) begin
            if (!l_wr) begin
                if (cache_valid && l_addr[19:1] == cache_tag) begin
                    dato_nxt = l_addr[0] ? cache_word[15:8] : cache_word[7:0];
                end else begin
                    state_nxt    = S_RD;
                    cnt_nxt      = CW'(WAIT_RD);
                    mem_addr_nxt = l_addr[19:1];
                    byte_sel_nxt = l_addr[0];
                    mem_ce_n_nxt = 1'b0;
                    mem_oe_n_nxt = 1'b0;
                    mem_ub_n_nxt = 1'b0;
                    mem_lb_n_nxt = 1'b0;
                end
            end else begin
                state_nxt     = S_WR;
                cnt_nxt       = CW'(WAIT_WR);
                mem_addr_nxt  = l_addr[19:1];
                mem_dq_o_nxt  = {l_dati, l_dati};
                mem_dq_oe_nxt = 1'b1;
                mem_ce_n_nxt  = 1'b0;
                mem_we_n_nxt  = 1'b0;
                mem_lb_n_nxt  = l_addr[0];
                mem_ub_n_nxt  = ~l_addr[0];
                // Write-through keeps the cached word coherent with PSRAM.
                if (cache_valid && l_addr[19:1] == cache_tag) begin
                    if (l_addr[0]) cache_word_nxt[15:8] = l_dati;
                    else           cache_word_nxt[7:0]  = l_dati;
                end
            end
        end

        busy_nxt = (state_nxt != S_IDLE) | pend_valid_nxt;
    end

endmodule

// File: tb/tb_huc_rom_port.sv
// tb_huc_rom_port
// Self-checking bench for huc_rom_port: directed scenarios for cache hit/miss,
// byte-lane writes, write-through, pending/overflow, simultaneous strobes and
// mid-cycle reset, followed by randomized single transactions checked against
// a transaction-level model (byte memory image plus a one-word cache tag).
module tb_huc_rom_port;

    localparam int WRD  = 4;
    localparam int WWR  = 4;
    localparam int RECC = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce, oe, we;
    logic [19:0] addr;
    logic [7:0]  dati;
    logic [7:0]  dato;
    logic        busy, ovf;
    logic [18:0] mem_addr;
    logic [15:0] mem_dq_i, mem_dq_o;
    logic        mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n;

    int compCount = 0;
    int failCount = 0;
    int ceLow, oeLow, weLow;
    int overlapCount = 0;

    logic [15:0] psram  [int];
    logic [7:0]  refMem [int];
    logic [15:0] tbWord;

    bit          modelValid;
    int          modelWord;
    logic [7:0]  expDato;

    huc_rom_port #(.WAIT_RD(WRD), .WAIT_WR(WWR), .REC(RECC)) dut (
        .clk(clk), .rst(rst), .ce(ce), .oe(oe), .we(we), .addr(addr), .dati(dati),
        .dato(dato), .busy(busy), .ovf(ovf), .mem_addr(mem_addr),
        .mem_dq_i(mem_dq_i), .mem_dq_o(mem_dq_o), .mem_dq_oe(mem_dq_oe),
        .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
        .mem_ub_n(mem_ub_n), .mem_lb_n(mem_lb_n)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] defWord(input int w);
        logic [15:0] x;
        x = w[15:0];
        return {x[7:0] ^ 8'h3C, x[15:8] ^ x[7:0] ^ 8'h96};
    endfunction

    function automatic logic [15:0] devWord(input int w);
        if (psram.exists(w)) return psram[w];
        return defWord(w);
    endfunction

    function automatic logic [7:0] refByte(input int a);
        logic [15:0] w;
        if (refMem.exists(a)) return refMem[a];
        w = defWord(a >> 1);
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    // PSRAM device model and strobe monitor, all on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (!mem_ce_n) ceLow++;
            if (!mem_oe_n) oeLow++;
            if (!mem_we_n) weLow++;
            if (mem_dq_oe && !mem_oe_n) overlapCount++;
            if (!mem_ce_n && !mem_we_n) begin
                tbWord = devWord(int'(mem_addr));
                if (!mem_lb_n) tbWord[7:0]  = mem_dq_o[7:0];
                if (!mem_ub_n) tbWord[15:8] = mem_dq_o[15:8];
                psram[int'(mem_addr)] = tbWord;
            end
        end
        mem_dq_i = devWord(int'(mem_addr));
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearCounts();
        ceLow = 0;
        oeLow = 0;
        weLow = 0;
    endtask

    // Raise the strobes for one cycle; returns at the falling edge after E0.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [19:0] a, input logic [7:0] d);
        @(negedge clk);
        ce   = 1'b1;
        oe   = rd;
        we   = wr;
        addr = a;
        dati = d;
        @(negedge clk);
        ce = 1'b0;
        oe = 1'b0;
        we = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_reached", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int  op;
        int  ai;
        bit  isRd, isWr;
        int  expCe, expOe, expWe;
        logic [7:0] d;

        rst = 1'b1; ce = 1'b0; oe = 1'b0; we = 1'b0; addr = '0; dati = '0;
        psram[0] = 16'hBEEF;
        refMem[0] = 8'hEF;
        refMem[1] = 8'hBE;
        modelValid = 1'b0;
        modelWord = 0;
        clearCounts();

        repeat (2) @(negedge clk);
        checkOutput("rst_strobes", {27'b0, mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n}, 32'h1F);
        checkOutput("rst_dato", {24'b0, dato}, 32'hFF);
        checkOutput("rst_busy_ovf_oe", {29'b0, busy, ovf, mem_dq_oe}, 32'd0);
        checkOutput("rst_addr_dq", {mem_addr[15:0], mem_dq_o}, 32'd0);
        rst = 1'b0;

        // Read miss on word 0 then hit on the upper byte.
        clearCounts();
        applyStimulus(1'b1, 1'b0, 20'h00000, 8'h00);
        checkOutput("miss_e0_busy", {31'b0, busy}, 32'd1);
        checkOutput("miss_e0_strobes", {30'b0, mem_ce_n, mem_oe_n}, 32'd0);
        checkOutput("miss_e0_addr", {13'b0, mem_addr}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("miss_e3_dato", {24'b0, dato}, 32'hFF);
        @(negedge clk);
        checkOutput("miss_e4_dato", {24'b0, dato}, 32'hEF);
        checkOutput("miss_e4_ce_busy", {30'b0, mem_ce_n, busy}, 32'h3);
        @(negedge clk);
        checkOutput("miss_e5_busy", {31'b0, busy}, 32'd0);
        checkOutput("miss_ce_cycles", ceLow, WRD);
        modelValid = 1'b1;
        modelWord = 0;

        clearCounts();
        applyStimulus(1'b1, 1'b0, 20'h00001, 8'h00);
        checkOutput("hit_dato", {24'b0, dato}, 32'hBE);
        checkOutput("hit_busy", {31'b0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("hit_no_ce", ceLow, 0);

        // Upper-lane write.
        clearCounts();
        applyStimulus(1'b0, 1'b1, 20'h00003, 8'h5A);
        checkOutput("wr_addr", {13'b0, mem_addr}, 32'd1);
        checkOutput("wr_lanes", {30'b0, mem_ub_n, mem_lb_n}, 32'b01);
        checkOutput("wr_dq", {15'b0, mem_dq_oe, mem_dq_o}, 32'h15A5A);
        waitIdle(50);
        checkOutput("wr_we_cycles", weLow, WWR);
        checkOutput("wr_dq_oe_off", {31'b0, mem_dq_oe}, 32'd0);
        refMem[3] = 8'h5A;

        // Write-through into the cached word 1.
        applyStimulus(1'b1, 1'b0, 20'h00002, 8'h00);
        waitIdle(50);
        checkOutput("wt_fill_dato", {24'b0, dato}, {24'b0, refByte(2)});
        modelWord = 1;
        applyStimulus(1'b0, 1'b1, 20'h00002, 8'h77);
        waitIdle(50);
        refMem[2] = 8'h77;
        clearCounts();
        applyStimulus(1'b1, 1'b0, 20'h00002, 8'h00);
        checkOutput("wt_hit_dato", {24'b0, dato}, 32'h77);
        applyStimulus(1'b1, 1'b0, 20'h00003, 8'h00);
        checkOutput("wt_hit_hi_dato", {24'b0, dato}, 32'h5A);
        checkOutput("wt_no_read", ceLow, 0);

        // Pending slot and overflow.
        clearCounts();
        applyStimulus(1'b1, 1'b0, 20'h10000, 8'h00);
        applyStimulus(1'b1, 1'b0, 20'h20000, 8'h00);
        checkOutput("pend_ovf_before", {31'b0, ovf}, 32'd0);
        applyStimulus(1'b0, 1'b1, 20'h30000, 8'hC3);
        checkOutput("pend_ovf_set", {30'b0, ovf, busy}, 32'h3);
        waitIdle(100);
        checkOutput("pend_dato", {24'b0, dato}, {24'b0, refByte(32'h20000)});
        checkOutput("pend_addr", {13'b0, mem_addr}, 32'h10000);
        checkOutput("pend_ce_cycles", ceLow, 2 * WRD);
        checkOutput("pend_dropped_wr", weLow, 0);
        checkOutput("pend_ovf_sticky", {31'b0, ovf}, 32'd1);
        modelWord = 32'h10000;
        expDato = dato;

        // Simultaneous oe/we rise: write only.
        clearCounts();
        applyStimulus(1'b1, 1'b1, 20'h00004, 8'h11);
        checkOutput("both_strobes", {30'b0, mem_we_n, mem_oe_n}, 32'b01);
        waitIdle(50);
        checkOutput("both_no_rd", oeLow, 0);
        checkOutput("both_we_cycles", weLow, WWR);
        checkOutput("both_dato_kept", {24'b0, dato}, {24'b0, expDato});
        refMem[4] = 8'h11;
        applyStimulus(1'b1, 1'b0, 20'h00004, 8'h00);
        waitIdle(50);
        checkOutput("both_readback", {24'b0, dato}, 32'h11);
        modelWord = 2;

        // Reset two cycles into a read.
        applyStimulus(1'b1, 1'b0, 20'h00007, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("mrst_strobes", {27'b0, mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n}, 32'h1F);
        checkOutput("mrst_dato", {24'b0, dato}, 32'hFF);
        checkOutput("mrst_busy_ovf", {30'b0, busy, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        modelValid = 1'b0;
        clearCounts();
        applyStimulus(1'b1, 1'b0, 20'h00001, 8'h00);
        waitIdle(50);
        checkOutput("mrst_miss_ce", ceLow, WRD);
        checkOutput("mrst_miss_dato", {24'b0, dato}, {24'b0, refByte(1)});
        modelValid = 1'b1;
        modelWord = 0;
        expDato = dato;

        // Randomized single transactions against the model.
        for (int i = 0; i < 40; i++) begin
            op   = $urandom_range(0, 2);
            ai   = $urandom_range(0, 31);
            d    = 8'($urandom);
            isWr = (op != 0);
            isRd = (op != 1);
            clearCounts();
            applyStimulus(isRd, isWr, 20'(ai), d);
            waitIdle(50);
            if (isWr) begin
                refMem[ai] = d;
                expCe = WWR; expOe = 0; expWe = WWR;
            end else begin
                expWe = 0;
                if (modelValid && modelWord == (ai >> 1)) begin
                    expCe = 0; expOe = 0;
                end else begin
                    expCe = WRD; expOe = WRD;
                    modelValid = 1'b1;
                    modelWord = ai >> 1;
                end
                expDato = refByte(ai);
            end
            checkOutput($sformatf("rnd%0d_dato", i), {24'b0, dato}, {24'b0, expDato});
            checkOutput($sformatf("rnd%0d_ce", i), ceLow, expCe);
            checkOutput($sformatf("rnd%0d_oe", i), oeLow, expOe);
            checkOutput($sformatf("rnd%0d_we", i), weLow, expWe);
        end

        checkOutput("ovf_clear_after_reset", {31'b0, ovf}, 32'd0);
        checkOutput("dq_oe_overlap", overlapCount, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
